pattern_detect_ctrl: RTL and testbench

Programmable serial pattern-detection controller.
- Holds a loadable pattern, length and overlap mode.
- Arms on a start request and examines a fixed window of valid input bits.
- Emits a Mealy match pulse per detection, counts matches, and signals done at window end.
- Sits between the register/config interface and the serial bit stream. It replaces hard-coded per-pattern detector FSMs.

---
 rtl/pd_pkg.sv | 27 ++
 rtl/pattern_match_core.sv | 51 +++++
 rtl/pattern_detect_ctrl.sv | 130 +++++++++++++
 tb/tb_pattern_detect_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pd_pkg.sv
// Shared types and helpers for the programmable pattern detector.
// Holds the FSM state enum, default widths and the length-mask builder.
package pd_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_WIN_W   = 16;
    localparam int LEN_W       = $clog2(DEF_MAX_LEN + 1);
    localparam int MASK_W      = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Low 'len' bits set; wide enough for any legal pattern length.
    function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            if (i < len) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/pattern_match_core.sv
// Bit history, fill counter and masked comparator for the pattern detector.
// Ports: clear/shift_en control, bit_in data, pattern/len/overlap config, hit.
module pattern_match_core
    import pd_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               bit_in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LW-1:0]      len,
    input  logic               overlap,
    output logic               hit
);

    logic [MAX_LEN-2:0] hist;
    logic [LW-1:0]      fill;
    logic [MAX_LEN-1:0] window;
    logic [MASK_W-1:0]  mask;
    logic [MASK_W-1:0]  diff;
    logic               fill_ok;

    // Newest bit sits in the LSB, so the completing bit is included.
    assign window  = {hist, bit_in};
    assign mask    = len_mask(32'(len));
    assign diff    = MASK_W'(window ^ pattern) & mask;
    assign fill_ok = ({1'b0, fill} + (LW+1)'(1)) >= {1'b0, len};
    assign hit     = shift_en & fill_ok & (diff == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= window[MAX_LEN-2:0];
            // Non-overlap: the next match must be built from fresh bits.
            if (hit && !overlap)
                fill <= '0;
            else if (fill != LW'(MAX_LEN))
                fill <= fill + LW'(1);
        end
    end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Run controller: config registers, FSM, window and match counters.
// Ports: cfg_* config, start/abort, bit_valid/bit_in, busy/match/count/done/err.
module pattern_detect_ctrl
    import pd_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int WIN_W   = DEF_WIN_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_we,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic [WIN_W-1:0]             cfg_win,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         bit_valid,
    input  logic                         bit_in,
    output logic                         busy,
    output logic                         match,
    output logic [CNT_W-1:0]             match_count,
    output logic                         done,
    output logic                         err_cfg
);

    localparam int LW = $clog2(MAX_LEN + 1);

    state_t             st;
    logic [MAX_LEN-1:0] pat_q;
    logic [LW-1:0]      len_q;
    logic               ovl_q;
    logic [WIN_W-1:0]   win_q;
    logic [WIN_W-1:0]   bcnt;
    logic [WIN_W-1:0]   bcnt_nx;

    logic [LW-1:0]      eff_len;
    logic [WIN_W-1:0]   eff_win;
    logic               cfg_ok;
    logic               start_ok;
    logic               shift_en;
    logic               hit;

    // A write in the same cycle as start is checked, not the stale value.
    assign eff_len  = cfg_we ? cfg_len : len_q;
    assign eff_win  = cfg_we ? cfg_win : win_q;
    assign cfg_ok   = (eff_len != '0) && (eff_len <= LW'(MAX_LEN))
                   && (eff_win != '0);
    assign start_ok = (st == IDLE) && start && cfg_ok;
    assign shift_en = (st == RUN) && bit_valid && !abort;
    assign bcnt_nx  = bcnt + WIN_W'(1);
    assign match    = hit;

    pattern_match_core #(
        .MAX_LEN (MAX_LEN),
        .LW      (LW)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_ok),
        .shift_en (shift_en),
        .bit_in   (bit_in),
        .pattern  (pat_q),
        .len      (len_q),
        .overlap  (ovl_q),
        .hit      (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            win_q       <= '0;
            bcnt        <= '0;
            match_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_cfg     <= 1'b0;
        end else begin
            done    <= 1'b0;
            err_cfg <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (cfg_we) begin
                        pat_q <= cfg_pattern;
                        len_q <= cfg_len;
                        ovl_q <= cfg_overlap;
                        win_q <= cfg_win;
                    end
                    if (start) begin
                        if (cfg_ok) begin
                            st          <= RUN;
                            busy        <= 1'b1;
                            bcnt        <= '0;
                            match_count <= '0;
                        end else begin
                            err_cfg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        st   <= IDLE;
                        busy <= 1'b0;
                    end else if (bit_valid) begin
                        bcnt <= bcnt_nx;
                        if (hit && (match_count != '1))
                            match_count <= match_count + CNT_W'(1);
                        if (bcnt_nx == win_q) begin
                            st   <= DONE;
                            done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    st   <= IDLE;
                    busy <= 1'b0;
                end
                default: begin
                    st   <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Directed bench for pattern_detect_ctrl with a 2-bit match counter.
// Drives on the falling edge, checks match before and registers after posedge.
module tb_pattern_detect_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int WIN_W   = 16;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic [WIN_W-1:0]   cfg_win;
    logic               start;
    logic               abort;
    logic               bit_valid;
    logic               bit_in;
    logic               busy;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               done;
    logic               err_cfg;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pattern_detect_ctrl #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W),
        .WIN_W   (WIN_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_win     (cfg_win),
        .start       (start),
        .abort       (abort),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .busy        (busy),
        .match       (match),
        .match_count (match_count),
        .done        (done),
        .err_cfg     (err_cfg)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l,
                           input logic o, input logic [WIN_W-1:0] w,
                           input logic st);
        @(negedge clk);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_win     = w;
        cfg_we      = 1'b1;
        start       = st;
        tick();
        cfg_we = 1'b0;
        start  = 1'b0;
    endtask

    task automatic go();
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic b, input logic ab, input logic exp_m,
                        input string tag);
        @(negedge clk);
        bit_valid = 1'b1;
        bit_in    = b;
        abort     = ab;
        #1 check(tag, 32'(match), 32'(exp_m));
        tick();
        bit_valid = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic gap();
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'b1;
        #1 check("gap_match", 32'(match), 0);
        tick();
    endtask

    logic s1 [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic e1 [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic e2 [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic s4 [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic e4 [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n       = 1'b0;
        cfg_we      = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        cfg_win     = '0;
        start       = 1'b0;
        abort       = 1'b0;
        bit_valid   = 1'b0;
        bit_in      = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(match_count), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err_cfg), 0);
        check("rst_match", 32'(match), 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // 101, non-overlap, window 5
        set_cfg(8'b101, 4'd3, 1'b0, 16'd5, 1'b0);
        go();
        check("t1_busy", 32'(busy), 1);
        check("t1_count0", 32'(match_count), 0);
        for (int i = 0; i < 5; i++) send(s1[i], 1'b0, e1[i], "t1_match");
        check("t1_done", 32'(done), 1);
        check("t1_busy_done", 32'(busy), 1);
        check("t1_count", 32'(match_count), 1);
        tick();
        check("t1_done_off", 32'(done), 0);
        check("t1_idle", 32'(busy), 0);
        check("t1_hold", 32'(match_count), 1);

        // Same stream, overlap
        set_cfg(8'b101, 4'd3, 1'b1, 16'd5, 1'b0);
        go();
        for (int i = 0; i < 5; i++) send(s1[i], 1'b0, e2[i], "t2_match");
        check("t2_done", 32'(done), 1);
        check("t2_count", 32'(match_count), 2);
        tick();

        // Illegal configs
        set_cfg(8'b101, 4'd0, 1'b0, 16'd5, 1'b0);
        go();
        check("t3_err_len", 32'(err_cfg), 1);
        check("t3_busy", 32'(busy), 0);
        check("t3_count", 32'(match_count), 2);
        tick();
        check("t3_err_off", 32'(err_cfg), 0);
        set_cfg(8'b101, 4'd3, 1'b0, 16'd0, 1'b1);
        check("t3_err_win", 32'(err_cfg), 1);
        check("t3_busy2", 32'(busy), 0);

        // 1101 with gaps and an ignored mid-run write
        set_cfg(8'b1101, 4'd4, 1'b0, 16'd8, 1'b0);
        go();
        for (int i = 0; i < 8; i++) begin
            send(s4[i], 1'b0, e4[i], "t4_match");
            if (i == 1) begin
                @(negedge clk);
                cfg_pattern = 8'b0;
                cfg_len     = 4'd2;
                cfg_win     = 16'd3;
                cfg_we      = 1'b1;
                tick();
                cfg_we = 1'b0;
            end
            if (i < 7) gap();
        end
        check("t4_done", 32'(done), 1);
        check("t4_count", 32'(match_count), 2);
        tick();

        // Abort on a completing bit
        set_cfg(8'b110, 4'd3, 1'b0, 16'd8, 1'b0);
        go();
        send(1'b1, 1'b0, 1'b0, "t5_match");
        send(1'b1, 1'b0, 1'b0, "t5_match");
        send(1'b0, 1'b0, 1'b1, "t5_match");
        send(1'b1, 1'b0, 1'b0, "t5_match");
        send(1'b1, 1'b0, 1'b0, "t5_match");
        send(1'b0, 1'b1, 1'b0, "t5_abort_match");
        check("t5_busy", 32'(busy), 0);
        check("t5_done", 32'(done), 0);
        check("t5_count", 32'(match_count), 1);
        tick();
        check("t5_done2", 32'(done), 0);

        // Saturation, then asynchronous reset mid-run
        set_cfg(8'b1, 4'd1, 1'b0, 16'd6, 1'b0);
        go();
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 1'b0, 1'b1, "t6_match");
            check("t6_count", 32'(match_count), (i < 3) ? i + 1 : 3);
        end
        check("t6_busy", 32'(busy), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_count", 32'(match_count), 0);
        check("t6_rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        go();
        check("t6_cfg_cleared", 32'(err_cfg), 1);
        check("t6_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
